// File: rtl/systolic_skew_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : systolic_skew_feeder_if
// Brief    : Operand/control bundle between tile sequencer and skew feeder.
// Revision : 1.0
// ============================================================================
interface systolic_skew_feeder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_SIZE = 4,
    parameter int MAX_K      = 256
);
    localparam int DIAG_NUM = 2 * ARRAY_SIZE - 1;
    localparam int KW       = $clog2(MAX_K + 1);

    logic                                  start;
    logic [KW-1:0]                         k_len;
    logic                                  busy;
    logic                                  in_valid;
    logic                                  in_ready;
    logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] ifm_vec;
    logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] w_vec;
    logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] ifm_out;
    logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] w_out;
    logic [DIAG_NUM-1:0]                   done;
    logic                                  tile_done;

    modport master (
        output start, k_len, in_valid, ifm_vec, w_vec,
        input  busy, in_ready, ifm_out, w_out, done, tile_done
    );

    modport slave (
        input  start, k_len, in_valid, ifm_vec, w_vec,
        output busy, in_ready, ifm_out, w_out, done, tile_done
    );
endinterface
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : systolic_skew_feeder
// Brief    : Diagonal-skew operand feeder with per-diagonal done pulses.
// Revision : 1.0
// ============================================================================
module systolic_skew_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_SIZE = 4,
    parameter int MAX_K      = 256
) (
    input  wire logic              clk,
    input  wire logic              rst,
    systolic_skew_feeder_if.slave  feed
);
    localparam int DIAG_NUM = 2 * ARRAY_SIZE - 1;
    localparam int KW       = $clog2(MAX_K + 1);
    localparam int DCW      = $clog2(DIAG_NUM + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q;
    logic [KW-1:0]       k_len_q;
    logic [KW-1:0]       beat_cnt_q;
    logic [DCW-1:0]      drain_cnt_q;
    logic                busy_q;
    logic                in_ready_q;
    logic                tile_done_q;
    logic [DIAG_NUM-1:0] done_q;

    logic                                  w_accept;
    logic                                  w_last;
    logic                                  w_start_ok;
    logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] ifm_d;
    logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] w_d;
    logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] w_ifm_out;
    logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] w_w_out;

    assign w_accept   = feed.in_valid & in_ready_q;
    assign w_last     = w_accept && ((beat_cnt_q + KW'(1)) == k_len_q);
    assign w_start_ok = feed.start && (feed.k_len != '0) && (feed.k_len <= KW'(MAX_K));

    // Unaccepted cycles enter the pipeline as zero pairs so the PEs accumulate nothing.
    assign ifm_d = w_accept ? feed.ifm_vec : '0;
    assign w_d   = w_accept ? feed.w_vec   : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_len_q     <= '0;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            tile_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        k_len_q    <= feed.k_len;
                        beat_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                        state_q    <= ST_FEED;
                    end
                end
                ST_FEED: begin
                    if (w_accept) begin
                        beat_cnt_q <= beat_cnt_q + KW'(1);
                    end
                    if (w_last) begin
                        in_ready_q  <= 1'b0;
                        drain_cnt_q <= '0;
                        state_q     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt_q <= drain_cnt_q + DCW'(1);
                    if (drain_cnt_q == DCW'(DIAG_NUM - 1)) begin
                        tile_done_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    tile_done_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b0;
                    tile_done_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    // Diagonal d sees the last operand pair d cycles after diagonal 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= '0;
        end else begin
            done_q <= {done_q[DIAG_NUM-2:0], w_last};
        end
    end

    // Lane i holds i+1 stages so its operand lands i cycles after lane 0.
    for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
        logic [DATA_WIDTH-1:0] ifm_sr_q [0:gi];
        logic [DATA_WIDTH-1:0] w_sr_q   [0:gi];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k <= gi; k++) begin
                    ifm_sr_q[k] <= '0;
                    w_sr_q[k]   <= '0;
                end
            end else begin
                ifm_sr_q[0] <= ifm_d[gi];
                w_sr_q[0]   <= w_d[gi];
                for (int k = 1; k <= gi; k++) begin
                    ifm_sr_q[k] <= ifm_sr_q[k-1];
                    w_sr_q[k]   <= w_sr_q[k-1];
                end
            end
        end

        assign w_ifm_out[gi] = ifm_sr_q[gi];
        assign w_w_out[gi]   = w_sr_q[gi];
    end

    assign feed.ifm_out   = w_ifm_out;
    assign feed.w_out     = w_w_out;
    assign feed.done      = done_q;
    assign feed.tile_done = tile_done_q;
    assign feed.busy      = busy_q;
    assign feed.in_ready  = in_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_skew_feeder
// Brief    : Directed scoreboard bench for systolic_skew_feeder (4x4, 8-bit).
// Revision : 1.0
// ============================================================================
module tb_systolic_skew_feeder;
    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int DN   = 2 * N - 1;
    localparam int MAXR = 300;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    systolic_skew_feeder_if #(.DATA_WIDTH(DW), .ARRAY_SIZE(N), .MAX_K(256)) bus ();

    systolic_skew_feeder #(.DATA_WIDTH(DW), .ARRAY_SIZE(N), .MAX_K(256)) dut (
        .clk  (clk),
        .rst  (rst),
        .feed (bus)
    );

    typedef struct {
        int              cyc;
        logic [N*DW-1:0] ifm;
        logic [N*DW-1:0] w;
        logic [DN-1:0]   done;
        logic            td;
        logic            busy;
        logic            rdy;
    } frame_t;

    frame_t exp_q[$];
    frame_t mf;

    // Stimulus per relative cycle of a scenario
    logic            st_start [0:MAXR-1];
    logic [8:0]      st_klen  [0:MAXR-1];
    logic            st_valid [0:MAXR-1];
    logic            st_rst   [0:MAXR-1];
    logic [N*DW-1:0] st_ifm   [0:MAXR-1];
    logic [N*DW-1:0] st_w     [0:MAXR-1];
    // Expected outputs per relative cycle
    logic [N*DW-1:0] e_ifm  [0:MAXR-1];
    logic [N*DW-1:0] e_w    [0:MAXR-1];
    logic [DN-1:0]   e_done [0:MAXR-1];
    logic            e_td   [0:MAXR-1];
    logic            e_busy [0:MAXR-1];
    logic            e_rdy  [0:MAXR-1];
    int              beat_q[$];

    function automatic logic [N*DW-1:0] beat_vec(int b, logic [7:0] mask);
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = 8'(4 * b + i + 1) ^ mask;
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            mf = exp_q.pop_front();
            chk("ifm_out",   64'(bus.ifm_out),   64'(mf.ifm));
            chk("w_out",     64'(bus.w_out),     64'(mf.w));
            chk("done",      64'(bus.done),      64'(mf.done));
            chk("tile_done", 64'(bus.tile_done), 64'(mf.td));
            chk("busy",      64'(bus.busy),      64'(mf.busy));
            chk("in_ready",  64'(bus.in_ready),  64'(mf.rdy));
        end
    end

    task automatic clear_all();
        for (int r = 0; r < MAXR; r++) begin
            st_start[r] = 0; st_klen[r] = '0; st_valid[r] = 0; st_rst[r] = 0;
            st_ifm[r] = '0; st_w[r] = '0;
            e_ifm[r] = '0; e_w[r] = '0; e_done[r] = '0;
            e_td[r] = 0; e_busy[r] = 0; e_rdy[r] = 0;
        end
        beat_q.delete();
    endtask

    task automatic clear_expect_from(int r0);
        for (int r = r0; r < MAXR; r++) begin
            e_ifm[r] = '0; e_w[r] = '0; e_done[r] = '0;
            e_td[r] = 0; e_busy[r] = 0; e_rdy[r] = 0;
        end
    endtask

    task automatic put_start(int r, int k);
        st_start[r] = 1; st_klen[r] = 9'(k);
    endtask

    task automatic put_beat(int r, logic [7:0] mask);
        st_valid[r] = 1;
        st_ifm[r]   = beat_vec(beat_q.size(), 8'h00);
        st_w[r]     = beat_vec(beat_q.size(), mask);
        beat_q.push_back(r);
    endtask

    task automatic put_junk(int r);
        st_valid[r] = 1; st_ifm[r] = 32'hEEEE_EEEE; st_w[r] = 32'hDDDD_DDDD;
    endtask

    // Expected timeline of one tile started at s, with accepted beats in beat_q
    task automatic add_tile(int s, logic [7:0] mask);
        int t_last;
        logic [N*DW-1:0] v;
        t_last = beat_q[beat_q.size() - 1];
        for (int r = s + 1; r <= t_last; r++) e_rdy[r] = 1;
        for (int r = s + 1; r <= t_last + 2 * N; r++) e_busy[r] = 1;
        for (int d = 0; d < DN; d++) e_done[t_last + 1 + d][d] = 1'b1;
        e_td[t_last + 2 * N] = 1;
        for (int b = 0; b < beat_q.size(); b++) begin
            v = beat_vec(b, 8'h00);
            for (int i = 0; i < N; i++) e_ifm[beat_q[b] + 1 + i][i*DW +: DW] = v[i*DW +: DW];
            v = beat_vec(b, mask);
            for (int i = 0; i < N; i++) e_w[beat_q[b] + 1 + i][i*DW +: DW] = v[i*DW +: DW];
        end
    endtask

    task automatic run(int len);
        frame_t f;
        int s;
        s = cyc + 1;
        for (int r = 0; r < len; r++) begin
            f.cyc = s + r; f.ifm = e_ifm[r]; f.w = e_w[r]; f.done = e_done[r];
            f.td = e_td[r]; f.busy = e_busy[r]; f.rdy = e_rdy[r];
            exp_q.push_back(f);
        end
        for (int r = 0; r < len; r++) begin
            @(posedge clk);
            #1;
            rst          = st_rst[r];
            bus.start    = st_start[r];
            bus.k_len    = st_klen[r];
            bus.in_valid = st_valid[r];
            bus.ifm_vec  = st_ifm[r];
            bus.w_vec    = st_w[r];
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.start = 0; bus.k_len = '0; bus.in_valid = 0; bus.ifm_vec = '0; bus.w_vec = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset mid-FEED aborts silently, then a k_len=2 tile runs normally
        clear_all();
        put_start(0, 3);
        put_beat(1, 8'h5A);
        put_beat(2, 8'h5A);
        add_tile(0, 8'h5A);
        clear_expect_from(3);
        for (int r = 3; r <= 6; r++) put_junk(r);
        for (int r = 3; r <= 5; r++) st_rst[r] = 1;
        beat_q.delete();
        put_start(7, 2);
        put_beat(8, 8'h5A);
        put_beat(9, 8'h5A);
        add_tile(7, 8'h5A);
        run(20);

        // Basic tile, ignored start mid-tile, valid held in DRAIN/IDLE, back-to-back tile
        clear_all();
        put_start(0, 3);
        put_beat(1, 8'h00); put_beat(2, 8'h00); put_beat(3, 8'h00);
        add_tile(0, 8'h00);
        put_start(6, 5);
        for (int r = 4; r <= 12; r++) put_junk(r);
        beat_q.delete();
        put_start(12, 3);
        put_beat(13, 8'h00); put_beat(14, 8'h00); put_beat(15, 8'h00);
        add_tile(12, 8'h00);
        run(25);

        // Bubble at relative cycle 2
        clear_all();
        put_start(0, 3);
        put_beat(1, 8'hA5);
        st_ifm[2] = 32'h7777_7777; st_w[2] = 32'h6666_6666;
        put_beat(3, 8'hA5); put_beat(4, 8'hA5);
        add_tile(0, 8'hA5);
        run(14);

        // Illegal k_len ignored; start+valid together in IDLE; k_len=1
        clear_all();
        put_start(0, 0);
        put_start(2, 300);
        for (int r = 0; r <= 3; r++) put_junk(r);
        put_start(6, 1);
        put_junk(6);
        put_beat(7, 8'h33);
        add_tile(6, 8'h33);
        run(17);

        // k_len = MAX_K
        clear_all();
        put_start(0, 256);
        for (int r = 1; r <= 256; r++) put_beat(r, 8'h0F);
        add_tile(0, 8'h0F);
        run(266);

        repeat (3) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
